// File: rtl/alu_seq.sv
// alu_seq: sequential valid/ready front end for the combinational alu.
// Registers a request onto the alu inputs, captures the result one cycle
// later into a backpressured response register with a zero flag, and
// counts delivered responses.
// Optional feature macro: ALU_SEQ_ACC_EN adds the in_use_acc port and an
// accumulator holding the last delivered result, selectable as operand A.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
`ifdef ALU_SEQ_ACC_EN
    input  logic             in_use_acc,
`endif
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_select,
    input  logic [WIDTH-1:0] alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_resp_hs;
    logic [WIDTH-1:0] w_a_src;

    logic [WIDTH-1:0] r_a_p0;
    logic [WIDTH-1:0] r_b_p0;
    logic [1:0]       r_sel_p0;

    logic [WIDTH-1:0] r_data_p1;
    logic             r_zero_p1;
    logic             r_vld_p1;

    logic [CNT_W-1:0] r_cnt;

    // A new request may enter when idle, or when the held response leaves
    // in this same cycle; nothing is accepted while reset is asserted.
    assign w_in_ready = rst_n && ((r_state == ST_IDLE) ||
                                  ((r_state == ST_HOLD) && out_ready));
    assign w_accept   = in_valid && w_in_ready;
    assign w_resp_hs  = r_vld_p1 && out_ready;

`ifdef ALU_SEQ_ACC_EN
    logic [WIDTH-1:0] r_acc;

    // On a same-cycle handshake the result being handed over is newer than
    // the accumulator, so it is forwarded directly.
    assign w_a_src = in_use_acc ? (w_resp_hs ? r_data_p1 : r_acc) : in_a;

    // Accumulator tracks the most recently delivered result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_resp_hs) begin
            r_acc <= r_data_p1;
        end
    end
`else
    assign w_a_src = in_a;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: one EXEC cycle per operation, then HOLD until drained.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = w_accept ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---- stage p0: operand register driving the alu inputs ----
    // Operands are only replaced on accept, so they stay stable in HOLD and
    // keep their last value in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_p0   <= '0;
            r_b_p0   <= '0;
            r_sel_p0 <= '0;
        end else if (w_accept) begin
            r_a_p0   <= w_a_src;
            r_b_p0   <= in_b;
            r_sel_p0 <= in_op;
        end
    end

    // ---- stage p1: response register capturing the alu result ----
    // Captured only in EXEC, so data and zero flag are frozen while held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_p1 <= '0;
            r_zero_p1 <= 1'b0;
            r_vld_p1  <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_data_p1 <= alu_result;
            r_zero_p1 <= (alu_result == '0);
            r_vld_p1  <= 1'b1;
        end else if (w_resp_hs) begin
            r_vld_p1  <= 1'b0;
        end
    end

    // Delivered-response counter, wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_resp_hs) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready   = w_in_ready;
    assign alu_a      = r_a_p0;
    assign alu_b      = r_b_p0;
    assign alu_select = r_sel_p0;
    assign out_valid  = r_vld_p1;
    assign out_data   = r_data_p1;
    assign out_zero   = r_zero_p1;
    assign op_count   = r_cnt;

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential front end for the combinational `alu`. Accepts operation requests on a valid/ready handshake, registers operands and select code, drives them onto the `alu` input port, and captures the ALU result into a backpressured response register with a zero flag. It sits between the multi-cycle control path and the existing `alu` instance. The `alu` itself stays unchanged and is instantiated beside this block.

## Interface
- `WIDTH`, 32, operand/result width; must match the attached `alu`.
- `CNT_W`, 16, width of the completed-operation counter.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request this cycle.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `in_op`  in  2  00 add, 01 sub, 10 and, 11 or.
- `in_use_acc`  in  1  use last result as A; present only with `ALU_SEQ_ACC_EN`.
- `alu_a`  out  WIDTH  to `alu.A`.
- `alu_b`  out  WIDTH  to `alu.B`.
- `alu_select`  out  2  to `alu.select`.
- `alu_result`  in  WIDTH  from `alu.result`.
- `out_valid`  out  1  response valid.
- `out_ready`  in  1  consumer accepts response.
- `out_data`  out  WIDTH  captured result.
- `out_zero`  out  1  `out_data == 0`.
- `op_count`  out  CNT_W  responses delivered since reset.

## Operation
- FSM states: IDLE, EXEC, HOLD. Reset state is IDLE.
- `in_ready` = `rst_n` && ((IDLE) || (HOLD && `out_ready`)).
- Accept when `in_valid && in_ready`. Register `in_a`/`in_b`/`in_op` into `alu_a`/`alu_b`/`alu_select`, then go to EXEC.
- EXEC lasts one cycle. Capture `alu_result` into `out_data`, set `out_zero`, assert `out_valid`, then go to HOLD.
- HOLD: hold `out_valid`, `out_data`, `out_zero` and the `alu_*` outputs stable until `out_ready`.
  - `out_ready` with no `in_valid`: deassert `out_valid`, go to IDLE.
  - `out_ready` with `in_valid` in the same cycle: complete the response and accept the new request together, then go to EXEC.
- `in_valid` outside an accept cycle is ignored. No request is queued.
- `op_count` increments on every `out_valid && out_ready` and wraps at 2^CNT_W - 1 → 0.
- Arithmetic is performed by `alu`: modulo 2^WIDTH with no carry or overflow output. This block adds no arithmetic of its own.
- `alu_*` outputs keep their last value in IDLE. They are never forced to zero between operations.

## Timing
- Reset, applied on any clock edge with `rst_n` = 0:
  - FSM → IDLE.
  - `out_valid`, `out_zero`, `out_data`, `alu_a`, `alu_b`, `alu_select`, `op_count` → 0.
  - `in_ready` is 0 while `rst_n` is low.
- Latency: accepted at edge N → `alu_*` valid after N → `out_valid` high after edge N+1, i.e. 2 cycles.
- Maximum throughput is 1 operation per 2 cycles with `out_ready` held high.
- Reset in EXEC or HOLD drops the operation. No response is produced and `op_count` does not increment.
- Stability: while `out_valid` is high and `out_ready` is low, `out_data` and `out_zero` must not change.

## Configuration
- `ALU_SEQ_ACC_EN` defined:
  - `in_use_acc` port exists.
  - On accept with `in_use_acc` = 1, `alu_a` takes the internal accumulator instead of `in_a`.
  - The accumulator is loaded with `out_data` on every response handshake and resets to 0.
  - A request accepted in the same cycle as a response handshake uses the result being handed over in that cycle.
- `ALU_SEQ_ACC_EN` undefined:
  - No `in_use_acc` port and no accumulator register.
  - `alu_a` always takes `in_a`.

## Test plan
- Add: `in_a`=10, `in_b`=5, `in_op`=00 accepted at edge N, `out_ready`=1 → `out_valid` after edge N+1, `out_data`=15, `out_zero`=0, `op_count`=1.
- Sub wrap: 5 − 10 (op 01) → `out_data`=0xFFFFFFFB. Then 10 & 5 (op 10) → `out_data`=0, `out_zero`=1.
- Backpressure:
  - 10 | 5 (op 11) with `out_ready`=0 for 5 cycles → `out_data`=15 held stable and `in_ready`=0 throughout.
  - Raise `out_ready` together with a new request 100 + 5 → both handshakes occur in that cycle and the next response is 105.
- Back-to-back: 4 adds with `in_valid` and `out_ready` held high → responses spaced every 2 cycles, `op_count`=4.
- Reset mid-op: accept 10 + 5, pull `rst_n` low on the EXEC cycle → no `out_valid`, all outputs 0, `op_count`=0, `in_ready`=1 the cycle after `rst_n` rises.
- With `ALU_SEQ_ACC_EN`: 10 + 5 → 15, then `in_use_acc`=1, `in_b`=3, op 01 → `alu_a`=15, `out_data`=12.
